// File: rtl/rom_stepper.sv
// ROM address sequencer driven by debounced front-panel buttons.
// Single-step or free-run advance, gated by the ROM ready handshake.
module rom_stepper #(
  parameter int ADDR_WIDTH      = 16,
  parameter int LAST_ADDRESS    = 2**ADDR_WIDTH-1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RUN_DIVIDER     = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_step,
  input  logic                  btn_mode,
  input  logic                  rom_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  advance,
  output logic                  running,
  output logic                  wrapped,
  output logic                  pending
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(RUN_DIVIDER);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES-1);
  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_DIVIDER-1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDRESS);

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  // bit 0 = step button, bit 1 = mode button
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         db_q, db_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0]         press;

  mode_e           mode_q, mode_d;
  logic [RW-1:0]   div_q, div_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic            advance_q, advance_d;
  logic            wrapped_q, wrapped_d;
  logic            pending_q, pending_d;

  logic run_tick, req, pend_keep, want, fire;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    press = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          db_d[i]  = sync2_q[i];
          press[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Mode toggle is resolved first; the step press sees the new mode.
  always_comb begin
    mode_d = press[1] ? mode_e'(~mode_q) : mode_q;
    div_d  = div_q;
    if (press[1] && mode_d == MODE_RUN) begin
      div_d = '0;
    end else if (mode_q == MODE_RUN) begin
      div_d = (div_q == RUN_MAX) ? '0 : div_q + 1'b1;
    end
    run_tick  = (mode_q == MODE_RUN) && (mode_d == MODE_RUN)
                && (div_q == RUN_MAX);
    req       = (press[0] && mode_d == MODE_STEP) || run_tick;
    pend_keep = pending_q && !(press[1] && mode_q == MODE_RUN);
    want      = req || pend_keep;
    fire      = want && rom_ready;
    pending_d = want && !rom_ready;
    advance_d = fire;
    wrapped_d = fire && (address_q == LAST_A);
    address_d = address_q;
    if (fire) begin
      address_d = (address_q == LAST_A) ? '0 : address_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_STEP;
      div_q     <= '0;
      address_q <= '0;
      advance_q <= 1'b0;
      wrapped_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_mode, btn_step};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      address_q <= address_d;
      advance_q <= advance_d;
      wrapped_q <= wrapped_d;
      pending_q <= pending_d;
    end
  end

  assign address = address_q;
  assign advance = advance_q;
  assign running = (mode_q == MODE_RUN);
  assign wrapped = wrapped_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_rom_stepper.sv
// Scoreboard bench for rom_stepper: expected advances are queued by an
// event-level address model; a monitor pops and compares on each advance.
module tb_rom_stepper;

  localparam int AW   = 4;
  localparam int LAST = 5;
  localparam int DEB  = 4;
  localparam int RUN  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_step = 1'b0;
  logic          btn_mode = 1'b0;
  logic          rom_ready = 1'b0;
  logic [AW-1:0] address;
  logic          advance, running, wrapped, pending;

  rom_stepper #(
    .ADDR_WIDTH(AW),
    .LAST_ADDRESS(LAST),
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIVIDER(RUN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_step(btn_step),
    .btn_mode(btn_mode),
    .rom_ready(rom_ready),
    .address(address),
    .advance(advance),
    .running(running),
    .wrapped(wrapped),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int wrap;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_adv = 0;
  int   m_addr = 0;
  bit   m_pend = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void expect_adv();
    m_addr = (m_addr == LAST) ? 0 : m_addr + 1;
    sb.push_back('{m_addr, int'(m_addr == 0)});
  endfunction

  task automatic press(input bit s, input bit m,
                       input int hold, input int gap);
    btn_step = s;
    btn_mode = m;
    cyc(hold);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    cyc(gap);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    m_addr = 0;
    m_pend = 0;
  endtask

  always @(negedge clk) begin
    if (advance) begin
      n_adv++;
      if (sb.size() == 0) begin
        chk("unexpected_advance", 1, 0);
      end else begin
        e_m = sb.pop_front();
        chk("adv_addr", int'(address), e_m.addr);
        chk("adv_wrap", int'(wrapped), e_m.wrap);
      end
    end else if (wrapped) begin
      chk("wrap_without_advance", 1, 0);
    end
  end

  initial begin
    int a0;
    cyc(3);
    chk("rst_addr", int'(address), 0);
    chk("rst_adv", int'(advance), 0);
    chk("rst_run", int'(running), 0);
    chk("rst_wrap", int'(wrapped), 0);
    chk("rst_pend", int'(pending), 0);
    reset = 1'b0;
    cyc(2);

    // bounce then a clean hold gives exactly one advance
    rom_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn_step = ~btn_step;
      cyc(1);
    end
    expect_adv();
    btn_step = 1'b1;
    cyc(10);
    btn_step = 1'b0;
    cyc(12);
    chk("bounce_addr", int'(address), m_addr);
    btn_step = 1'b1;
    cyc(3);
    btn_step = 1'b0;
    cyc(12);
    chk("short_pulse_addr", int'(address), m_addr);

    // six clean presses wrap through LAST
    pulse_reset();
    cyc(2);
    a0 = n_adv;
    for (int i = 0; i < 6; i++) begin
      expect_adv();
      press(1'b1, 1'b0, DEB + 4, DEB + 6);
    end
    chk("wrap_addr", int'(address), 0);
    chk("wrap_count", n_adv - a0, 6);

    // ready gating with depth-one pending
    rom_ready = 1'b0;
    cyc(2);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, DEB + 4, DEB + 6);
    chk("gate_pend", int'(pending), 1);
    chk("gate_addr", int'(address), m_addr);
    expect_adv();
    rom_ready = 1'b1;
    cyc(3);
    chk("gate_pend_clr", int'(pending), 0);
    cyc(20);
    chk("gate_addr_after", int'(address), m_addr);

    // randomized presses against random ready levels
    for (int it = 0; it < 12; it++) begin
      bit rdy;
      rdy = 1'($urandom % 2);
      if (rdy && m_pend) begin
        expect_adv();
        m_pend = 0;
      end
      rom_ready = rdy;
      cyc(3);
      if (rdy) expect_adv();
      else m_pend = 1;
      press(1'b1, 1'b0, DEB + 2 + int'($urandom % 6),
            DEB + 6 + int'($urandom % 5));
      chk("rnd_pend", int'(pending), int'(m_pend));
      chk("rnd_addr", int'(address), m_addr);
    end
    if (m_pend) begin
      expect_adv();
      m_pend = 0;
    end
    rom_ready = 1'b1;
    cyc(4);
    chk("rnd_pend_final", int'(pending), 0);

    // run mode: six ticks between the two mode presses
    pulse_reset();
    cyc(2);
    a0 = n_adv;
    for (int i = 0; i < 6; i++) expect_adv();
    btn_mode = 1'b1;
    cyc(8);
    chk("run_on", int'(running), 1);
    btn_mode = 1'b0;
    cyc(12);
    btn_step = 1'b1;
    cyc(8);
    btn_step = 1'b0;
    cyc(24);
    btn_mode = 1'b1;
    cyc(8);
    btn_mode = 1'b0;
    chk("run_off", int'(running), 0);
    cyc(40);
    chk("run_count", n_adv - a0, 6);
    chk("run_addr", int'(address), 0);

    // reset while running with a pending request
    for (int i = 0; i < 3; i++) begin
      expect_adv();
      press(1'b1, 1'b0, DEB + 4, DEB + 6);
    end
    rom_ready = 1'b0;
    btn_mode = 1'b1;
    cyc(8);
    btn_mode = 1'b0;
    cyc(10);
    chk("pre_rst_run", int'(running), 1);
    chk("pre_rst_pend", int'(pending), 1);
    chk("pre_rst_addr", int'(address), 3);
    pulse_reset();
    chk("mid_rst_addr", int'(address), 0);
    chk("mid_rst_run", int'(running), 0);
    chk("mid_rst_pend", int'(pending), 0);
    chk("mid_rst_adv", int'(advance), 0);
    rom_ready = 1'b1;
    cyc(DEB + 6);
    chk("post_rst_addr", int'(address), 0);

    // simultaneous presses: mode wins, step is ignored in run
    press(1'b1, 1'b1, 8, 0);
    chk("sim_run", int'(running), 1);
    chk("sim_pend", int'(pending), 0);
    rom_ready = 1'b0;
    cyc(8);
    chk("sim_run_pend", int'(pending), 1);
    press(1'b0, 1'b1, 8, 0);
    chk("leave_run", int'(running), 0);
    chk("leave_pend", int'(pending), 0);
    rom_ready = 1'b1;
    cyc(20);
    chk("sim_addr", int'(address), m_addr);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_stepper.md
Name: rom_stepper

Overview:
Address sequencer that drives the instruction ROM read address from front-panel buttons.
- Synchronises and debounces the step and mode buttons in the system clock domain; raw buttons are never used as clocks.
- Supports single-step and free-run modes, gates every advance on the ROM ready handshake, and wraps at a programmable last address.
- Sits between the board buttons and the ROM address input, alongside the screen/LED logic in the top level.

Parameters:
ADDR_WIDTH, 16, width of the address output.
LAST_ADDRESS, 2**ADDR_WIDTH-1, highest address; the next advance wraps to 0.
DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles needed to accept a button level change (>=2).
RUN_DIVIDER, 1000000, clock cycles between advance ticks in run mode (>=2).

Ports:
clk  input  1  system clock, single domain.
reset  input  1  synchronous, active-high reset.
btn_step  input  1  raw step button, asynchronous, active-high.
btn_mode  input  1  raw mode-toggle button, asynchronous, active-high.
rom_ready  input  1  ROM ready; an advance may only take effect while high.
address  output  ADDR_WIDTH  current ROM read address.
advance  output  1  one-cycle strobe in the cycle address changes.
running  output  1  1 = run mode, 0 = step mode.
wrapped  output  1  one-cycle strobe when address goes LAST_ADDRESS -> 0.
pending  output  1  an advance is requested but blocked by rom_ready low.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: address=0, advance=0, running=0, wrapped=0, pending=0. Synchroniser flops, debounced levels, debounce counters and the run divider are all 0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce: per button, a counter increments while the synchronised level differs from the debounced level and clears to 0 when they match. When the counter reaches DEBOUNCE_CYCLES-1 with the levels still different, the debounced level flips and the counter clears.
- Press: a debounced 0->1 transition produces a one-cycle internal press. Release produces nothing.
- Press latency: the press is asserted 2 + DEBOUNCE_CYCLES cycles after the raw edge, ±1 cycle.
- Held button through reset: registers as one press once debounced after reset deasserts.
- Mode press: toggles running. On entering run mode the divider clears to 0. On leaving run mode any pending request is cleared.
- Step mode: a step press creates an advance request.
- Run mode: step presses are ignored. The divider counts 0..RUN_DIVIDER-1, wraps to 0, and creates an advance request on each wrap (cycle count == RUN_DIVIDER-1).
- Request and rom_ready high in the same cycle: the advance happens in the next cycle (address updates on the following edge, advance=1 that cycle), and pending stays 0.
- Request while rom_ready low: pending=1. The advance fires in the first cycle rom_ready is seen high, then pending returns to 0.
- Pending depth is one: further requests while pending=1 are dropped, never queued.
- Advance arithmetic: address becomes address+1. If address==LAST_ADDRESS it becomes 0 and wrapped=1 in the same cycle as advance. Arithmetic is modulo ADDR_WIDTH bits.
- Simultaneous step and mode presses in the same cycle: the mode toggle is applied first, and the step press is evaluated against the new mode.
- Reset mid-operation: reset takes priority over every other event and restores all reset values in the next cycle, including dropping any pending request.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
(Parameters for all scenarios: ADDR_WIDTH=4, LAST_ADDRESS=5, DEBOUNCE_CYCLES=4, RUN_DIVIDER=8.)
1. Debounce: rom_ready=1; btn_step toggles every cycle for 20 cycles, then holds high for 10 cycles -> exactly one advance, address 0->1. A pulse 3 cycles wide -> no advance.
2. Step with wrap: rom_ready=1; 6 clean presses -> address 1,2,3,4,5,0; wrapped=1 only on the 5->0 advance; advance=1 for exactly 6 cycles total.
3. Ready gating: rom_ready=0; 3 step presses -> pending=1, address stays 0. Raise rom_ready -> one advance to 1, pending=0, no further advances.
4. Run mode: a mode press sets running=1. With rom_ready=1 the address advances every 8 cycles (0->1->...->5->0). A step press during run changes nothing. A second mode press sets running=0 and advancing stops.
5. Reset mid-operation: in run mode at address=3 with pending=1, pulse reset for 1 cycle -> next cycle address=0, running=0, pending=0, advance=0. No advance for at least DEBOUNCE_CYCLES cycles while the buttons are low.
6. Simultaneous presses: step mode, step and mode pressed in the same cycle -> running=1 and no advance from the step press.
